// File: rtl/a5_keystream_gen_if.sv
// Session-control and keystream-stream bundle for a5_keystream_gen.
// master: key-management / consumer side (drives start, Key, frame, num_words, ks_ready).
// slave:  generator side (drives busy, ks_data, ks_valid, done).
interface a5_keystream_gen_if #(
   parameter int unsigned WORD_W = 1
);
   logic              start;
   logic [63:0]       Key;
   logic [21:0]       frame;
   logic [15:0]       num_words;
   logic              busy;
   logic [WORD_W-1:0] ks_data;
   logic              ks_valid;
   logic              ks_ready;
   logic              done;

   modport master (
      output start, Key, frame, num_words, ks_ready,
      input  busy, ks_data, ks_valid, done
   );

   modport slave (
      input  start, Key, frame, num_words, ks_ready,
      output busy, ks_data, ks_valid, done
   );
endinterface

// File: rtl/a5_keystream_gen.sv
// A5/1 keystream generator: loads a session key and frame number into three
// majority-clocked LFSRs, discards MIX_CYCLES steps, then emits num_words
// keystream words of WORD_W bits (first bit in MSB) over valid/ready.
// Ports: clk, rest (sync active-high reset), bus (a5_keystream_gen_if.slave):
//   start/Key/frame/num_words in, busy/ks_data/ks_valid/done out, ks_ready in.
module a5_keystream_gen #(
   parameter int unsigned WORD_W     = 1,
   parameter int unsigned MIX_CYCLES = 100
) (
   input logic            clk,
   input logic            rest,
   a5_keystream_gen_if.slave bus
);
   localparam int unsigned R1_W      = 19;
   localparam int unsigned R2_W      = 22;
   localparam int unsigned R3_W      = 23;
   localparam int unsigned KEY_W     = 64;
   localparam int unsigned FRAME_W   = 22;
   localparam int unsigned NUM_W     = 16;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned BIT_CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_FRAME, MIX, GEN} state_t;

   state_t               state;
   logic [R1_W-1:0]      r1;
   logic [R2_W-1:0]      r2;
   logic [R3_W-1:0]      r3;
   logic [KEY_W-1:0]     key_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [NUM_W-1:0]     gen_left;   // words still to be generated
   logic [NUM_W-1:0]     hs_left;    // words still to be handed over
   logic [WORD_W-1:0]    acc;

   logic                 fb1, fb2, fb3, maj, load_bit, ks_bit;
   logic                 handshake, advance, word_done;
   logic [R1_W-1:0]      r1_load, r1_maj;
   logic [R2_W-1:0]      r2_load, r2_maj;
   logic [R3_W-1:0]      r3_load, r3_maj;
   logic [WORD_W-1:0]    word_next;

   // Next-state candidates for the three registers in load and majority modes.
   always_comb begin
      fb1       = r1[18] ^ r1[17] ^ r1[16] ^ r1[13];
      fb2       = r2[21] ^ r2[20];
      fb3       = r3[22] ^ r3[21] ^ r3[20] ^ r3[7];
      maj       = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
      // key/frame are shifted right each load step so bit 0 is always the next one
      load_bit  = (state == LOAD_KEY) ? key_q[0] : frame_q[0];
      r1_load   = {r1[R1_W-2:0], fb1 ^ load_bit};
      r2_load   = {r2[R2_W-2:0], fb2 ^ load_bit};
      r3_load   = {r3[R3_W-2:0], fb3 ^ load_bit};
      r1_maj    = (r1[8]  == maj) ? {r1[R1_W-2:0], fb1} : r1;
      r2_maj    = (r2[10] == maj) ? {r2[R2_W-2:0], fb2} : r2;
      r3_maj    = (r3[10] == maj) ? {r3[R3_W-2:0], fb3} : r3;
      ks_bit    = r1_maj[R1_W-1] ^ r2_maj[R2_W-1] ^ r3_maj[R3_W-1];
      // truncation keeps the low WORD_W bits: accumulator shifted left, new bit at LSB
      word_next = WORD_W'({acc, ks_bit});
      handshake = bus.ks_valid & bus.ks_ready;
      // stalled while a word waits unaccepted; stop once every word is generated
      advance   = (gen_left != '0) & ~(bus.ks_valid & ~bus.ks_ready);
      word_done = advance & (bit_cnt == BIT_CNT_W'(WORD_W - 1));
   end

   // Session FSM, LFSR state and registered outputs.
   always_ff @(posedge clk) begin
      if (rest) begin
         state        <= IDLE;
         r1           <= '0;
         r2           <= '0;
         r3           <= '0;
         key_q        <= '0;
         frame_q      <= '0;
         cnt          <= '0;
         bit_cnt      <= '0;
         gen_left     <= '0;
         hs_left      <= '0;
         acc          <= '0;
         bus.busy     <= 1'b0;
         bus.ks_data  <= '0;
         bus.ks_valid <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  r1       <= '0;
                  r2       <= '0;
                  r3       <= '0;
                  key_q    <= bus.Key;
                  frame_q  <= bus.frame;
                  gen_left <= bus.num_words;
                  hs_left  <= bus.num_words;
                  cnt      <= '0;
                  bit_cnt  <= '0;
                  acc      <= '0;
                  bus.busy <= 1'b1;
                  state    <= LOAD_KEY;
               end
            end
            LOAD_KEY: begin
               r1    <= r1_load;
               r2    <= r2_load;
               r3    <= r3_load;
               key_q <= key_q >> 1;
               if (cnt == CNT_W'(KEY_W - 1)) begin
                  cnt   <= '0;
                  state <= LOAD_FRAME;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            LOAD_FRAME: begin
               r1      <= r1_load;
               r2      <= r2_load;
               r3      <= r3_load;
               frame_q <= frame_q >> 1;
               if (cnt == CNT_W'(FRAME_W - 1)) begin
                  cnt   <= '0;
                  state <= MIX;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            MIX: begin
               r1 <= r1_maj;
               r2 <= r2_maj;
               r3 <= r3_maj;
               if (cnt == CNT_W'(MIX_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= GEN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            GEN: begin
               if (hs_left == '0) begin
                  // empty session: finish without producing anything
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  if (advance) begin
                     r1  <= r1_maj;
                     r2  <= r2_maj;
                     r3  <= r3_maj;
                     acc <= word_next;
                     if (word_done) begin
                        bit_cnt     <= '0;
                        bus.ks_data <= word_next;
                        gen_left    <= gen_left - NUM_W'(1);
                     end else begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                     end
                  end
                  if (word_done) begin
                     bus.ks_valid <= 1'b1;
                  end else if (handshake) begin
                     bus.ks_valid <= 1'b0;
                  end
                  if (handshake) begin
                     hs_left <= hs_left - NUM_W'(1);
                     if (hs_left == NUM_W'(1)) begin
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.ks_valid <= 1'b0;
                        state        <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
